// File: rtl/wb_stage_if.sv
// Writeback-stage bus: EXU and LSU result handshakes in, register-file write,
// bypass and retire outputs.
interface wb_stage_if #(
  parameter int REG_W = 64,
  parameter int CNT_W = 64
);
  logic             exu_valid;
  logic             exu_ready;
  logic [4:0]       exu_rd;
  logic [REG_W-1:0] exu_data;
  logic             lsu_valid;
  logic             lsu_ready;
  logic [4:0]       lsu_rd;
  logic [REG_W-1:0] lsu_data;
  logic [2:0]       lsu_funct3;
  logic [2:0]       lsu_offset;
  logic [4:0]       w_addr;
  logic [REG_W-1:0] w_data;
  logic             w_ena;
  logic             fwd_valid;
  logic [4:0]       fwd_addr;
  logic [REG_W-1:0] fwd_data;
  logic             commit;
  logic [CNT_W-1:0] instret;

  modport master (
    output exu_valid, exu_rd, exu_data,
    output lsu_valid, lsu_rd, lsu_data, lsu_funct3, lsu_offset,
    input  exu_ready, lsu_ready,
    input  w_addr, w_data, w_ena, fwd_valid, fwd_addr, fwd_data, commit, instret
  );

  modport slave (
    input  exu_valid, exu_rd, exu_data,
    input  lsu_valid, lsu_rd, lsu_data, lsu_funct3, lsu_offset,
    output exu_ready, lsu_ready,
    output w_addr, w_data, w_ena, fwd_valid, fwd_addr, fwd_data, commit, instret
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: LSU-priority arbitration, load formatting, one registered
// register-file write per cycle, bypass copy and retire counter.
module wb_stage #(
  parameter int REG_W = 64,
  parameter int CNT_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  wb_stage_if.slave    bus
);

  logic             exu_acc;
  logic             acc;
  logic [4:0]       acc_rd;
  logic [REG_W-1:0] acc_data;
  logic [REG_W-1:0] ld_sh;
  logic [REG_W-1:0] ld_fmt;

  logic             w_ena_q;
  logic             commit_q;
  logic [4:0]       w_addr_q;
  logic [REG_W-1:0] w_data_q;
  logic [CNT_W-1:0] instret_q;

  // Readies are forced low while reset is held.
  assign bus.lsu_ready = rst;
  assign bus.exu_ready = rst & ~bus.lsu_valid;

  assign exu_acc = bus.exu_valid & ~bus.lsu_valid;
  assign acc     = bus.lsu_valid | exu_acc;

  // Zero fill from the top makes word-crossing bytes read as 0.
  assign ld_sh = bus.lsu_data >> {bus.lsu_offset, 3'b000};

  always_comb begin
    ld_fmt = ld_sh;
    case (bus.lsu_funct3)
      3'b000:  ld_fmt = {{(REG_W-8){ld_sh[7]}},   ld_sh[7:0]};
      3'b001:  ld_fmt = {{(REG_W-16){ld_sh[15]}}, ld_sh[15:0]};
      3'b010:  ld_fmt = {{(REG_W-32){ld_sh[31]}}, ld_sh[31:0]};
      3'b100:  ld_fmt = {{(REG_W-8){1'b0}},       ld_sh[7:0]};
      3'b101:  ld_fmt = {{(REG_W-16){1'b0}},      ld_sh[15:0]};
      3'b110:  ld_fmt = {{(REG_W-32){1'b0}},      ld_sh[31:0]};
      default: ld_fmt = ld_sh;
    endcase
  end

  always_comb begin
    acc_rd   = bus.exu_rd;
    acc_data = bus.exu_data;
    if (bus.lsu_valid) begin
      acc_rd   = bus.lsu_rd;
      acc_data = ld_fmt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_ena_q   <= 1'b0;
      commit_q  <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      instret_q <= '0;
    end else begin
      w_ena_q  <= acc & (acc_rd != 5'd0);
      commit_q <= acc;
      if (acc) begin
        w_addr_q  <= acc_rd;
        w_data_q  <= acc_data;
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign bus.w_ena     = w_ena_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.w_data    = w_data_q;
  assign bus.fwd_valid = w_ena_q;
  assign bus.fwd_addr  = w_addr_q;
  assign bus.fwd_data  = w_data_q;
  assign bus.commit    = commit_q;
  assign bus.instret   = instret_q;

endmodule
